// File: rtl/fpga_cfg_pkg.sv
// Shared types and CRC-8 helper for the configuration loader.
// The CRC trailer check is built only when CFG_CRC_EN is defined.
package fpga_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      DONE,
      ERR
   } cfg_state_t;

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;

   // One MSB-first CRC-8 step for a single serial bit.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      logic fb;
      fb = crc[7] ^ din;
      return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Byte stream into the configuration loader (valid/ready handshake).
interface fpga_cfg_loader_if;

   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/fpga_cfg_shifter.sv
// 8-bit MSB-first serialiser driving the configuration chain head.
// Exposes the outgoing bit for CRC tracking when CFG_CRC_EN is defined.
module fpga_cfg_shifter (
   input  logic       prog_clk,
   input  logic       reset_n,
   input  logic       clr,
   input  logic       load,
   input  logic [7:0] data,
   input  logic       shift,
   input  logic       discard,
`ifdef CFG_CRC_EN
   output logic       msb,
`endif
   output logic       empty,
   output logic       head,
   output logic       shift_en
);

   logic [7:0] sh;
   logic [3:0] sh_cnt;

   always_ff @(posedge prog_clk) begin
      if (!reset_n) begin
         sh       <= '0;
         sh_cnt   <= '0;
         head     <= 1'b0;
         shift_en <= 1'b0;
      end else begin
         shift_en <= 1'b0;
         if (clr || discard) begin
            sh     <= '0;
            sh_cnt <= '0;
         end else if (load) begin
            sh     <= data;
            sh_cnt <= 4'd8;
         end else if (shift) begin
            head     <= sh[7];
            shift_en <= 1'b1;
            sh       <= {sh[6:0], 1'b0};
            sh_cnt   <= sh_cnt - 4'd1;
         end
      end
   end

   always_comb begin
      empty = (sh_cnt == 4'd0);
   end

`ifdef CFG_CRC_EN
   always_comb begin
      msb = sh[7];
   end
`endif

endmodule

// File: rtl/fpga_cfg_loader.sv
// Bitstream loader: FSM and bit counter; holds fabric in reset until CHAIN_LEN bits shifted.
// Define CFG_CRC_EN to add a CRC-8 trailer byte check after the last bit.
module fpga_cfg_loader
   import fpga_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 64
) (
   input  logic               prog_clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   fpga_cfg_loader_if.slave   s,
   output logic               ccff_head,
   output logic               ccff_shift_en,
   output logic               fabric_reset,
   output logic               busy,
   output logic               cfg_done,
   output logic               cfg_err
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);

   cfg_state_t       state;
   logic [CNT_W-1:0] bits_left;
   logic             sh_empty;
   logic             ready;
   logic             accept;
   logic             start_ok;
   logic             clr;
   logic             shift;
   logic             discard;
`ifdef CFG_CRC_EN
   logic             sh_msb;
   logic [7:0]       crc;
`endif

   always_comb begin
      ready = 1'b0;
      case (state)
         LOAD:    ready = sh_empty && (bits_left != '0);
`ifdef CFG_CRC_EN
         CHECK:   ready = 1'b1;
`endif
         default: ready = 1'b0;
      endcase
   end

   always_comb begin
      s.s_ready = ready;
      accept    = s.s_valid && ready;
      start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
      clr       = abort || start_ok;
      shift     = (state == LOAD) && !sh_empty && (bits_left != '0);
      discard   = (state == LOAD) && (bits_left == '0);
   end

   fpga_cfg_shifter u_shifter (
      .prog_clk (prog_clk),
      .reset_n  (reset_n),
      .clr      (clr),
      .load     (accept && (state == LOAD)),
      .data     (s.s_data),
      .shift    (shift),
      .discard  (discard),
`ifdef CFG_CRC_EN
      .msb      (sh_msb),
`endif
      .empty    (sh_empty),
      .head     (ccff_head),
      .shift_en (ccff_shift_en)
   );

   always_ff @(posedge prog_clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         bits_left    <= '0;
         fabric_reset <= 1'b1;
         busy         <= 1'b0;
         cfg_done     <= 1'b0;
         cfg_err      <= 1'b0;
`ifdef CFG_CRC_EN
         crc          <= CRC8_INIT;
`endif
      end else if (abort) begin
         state        <= IDLE;
         bits_left    <= '0;
         fabric_reset <= 1'b1;
         busy         <= 1'b0;
         cfg_done     <= 1'b0;
         cfg_err      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state        <= LOAD;
                  bits_left    <= CNT_W'(CHAIN_LEN);
                  fabric_reset <= 1'b1;
                  busy         <= 1'b1;
                  cfg_done     <= 1'b0;
                  cfg_err      <= 1'b0;
`ifdef CFG_CRC_EN
                  crc          <= CRC8_INIT;
`endif
               end
            end
            LOAD: begin
               // bits_left hits zero on the edge of the last shift, so the
               // final shift_en pulse is already out when we leave LOAD.
               if (bits_left == '0) begin
`ifdef CFG_CRC_EN
                  state <= CHECK;
`else
                  state        <= DONE;
                  fabric_reset <= 1'b0;
                  busy         <= 1'b0;
                  cfg_done     <= 1'b1;
`endif
               end else if (shift) begin
                  bits_left <= bits_left - 1'b1;
`ifdef CFG_CRC_EN
                  crc       <= crc8_step(crc, sh_msb);
`endif
               end
            end
`ifdef CFG_CRC_EN
            CHECK: begin
               if (accept) begin
                  busy <= 1'b0;
                  if (s.s_data == crc) begin
                     state        <= DONE;
                     fabric_reset <= 1'b0;
                     cfg_done     <= 1'b1;
                  end else begin
                     state   <= ERR;
                     cfg_err <= 1'b1;
                  end
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed/randomised bench for fpga_cfg_loader with CHAIN_LEN=20 (CRC trailer path when CFG_CRC_EN).
module tb_fpga_cfg_loader;

   localparam int CHAIN_LEN = 20;
   localparam int NBYTES    = (CHAIN_LEN + 7) / 8;
   localparam int GUARD     = 400;

   logic prog_clk = 1'b0;
   logic reset_n  = 1'b0;
   logic start    = 1'b0;
   logic abort    = 1'b0;
   logic ccff_head, ccff_shift_en, fabric_reset, busy, cfg_done, cfg_err;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   last_shift_cyc = 0;
   int   guard_hit = 0;
   logic head_q[$];
   int   acc_cyc[$];
   logic [7:0] bytes [0:NBYTES];

   fpga_cfg_loader_if bus ();

   fpga_cfg_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
      .prog_clk      (prog_clk),
      .reset_n       (reset_n),
      .start         (start),
      .abort         (abort),
      .s             (bus),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .fabric_reset  (fabric_reset),
      .busy          (busy),
      .cfg_done      (cfg_done),
      .cfg_err       (cfg_err)
   );

   always #5 prog_clk = ~prog_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge and log any chain shift seen there.
   task automatic tick();
      @(negedge prog_clk);
      cyc++;
      if (ccff_shift_en === 1'b1) begin
         head_q.push_back(ccff_head);
         last_shift_cyc = cyc;
      end
   endtask

   function automatic logic [31:0] exp_bits(input int n);
      logic [31:0] v;
      logic [7:0]  b;
      v = '0;
      for (int i = 0; i < n; i++) begin
         b = bytes[i / 8];
         v = {v[30:0], b[7 - (i % 8)]};
      end
      return v;
   endfunction

   function automatic logic [31:0] got_bits(input int n);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v = {v[30:0], head_q[i]};
      return v;
   endfunction

`ifdef CFG_CRC_EN
   // CRC as polynomial long division of the message times x^8 by x^8+x^2+x+1.
   function automatic logic [7:0] model_crc(input int n);
      logic [8:0] r;
      logic [7:0] b;
      logic       bit_in;
      r = '0;
      for (int i = 0; i < n + 8; i++) begin
         b      = bytes[(i < n ? i : 0) / 8];
         bit_in = (i < n) ? b[7 - (i % 8)] : 1'b0;
         r      = {r[7:0], bit_in};
         if (r[8]) r = r ^ 9'h107;
      end
      return r[7:0];
   endfunction
`endif

   // Start a load with fresh random bytes; stop after stop_at shifts (0 = run to completion).
   task automatic run_load(input int stop_at, input bit poke_start, input bit bad_crc);
      int idx;
      int guard;
      bit poked;
      idx   = 0;
      guard = 0;
      poked = 0;
      guard_hit = 0;
      head_q.delete();
      acc_cyc.delete();
      for (int i = 0; i <= NBYTES; i++) bytes[i] = 8'($urandom);
`ifdef CFG_CRC_EN
      bytes[NBYTES] = model_crc(CHAIN_LEN) ^ (bad_crc ? 8'h5A : 8'h00);
`else
      if (bad_crc) bytes[NBYTES] = ~bytes[NBYTES];
`endif
      bus.s_data  = bytes[0];
      bus.s_valid = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_done_clear", cfg_done, 0);
      check("start_fabric_reset", fabric_reset, 1);
      while (!(cfg_done === 1'b1) && !(cfg_err === 1'b1) && guard < GUARD &&
             !(stop_at != 0 && head_q.size() >= stop_at)) begin
         if (bus.s_valid && bus.s_ready === 1'b1) begin
            acc_cyc.push_back(cyc);
            idx++;
         end
         start = 1'b0;
         if (poke_start && !poked && head_q.size() == 5) begin
            start = 1'b1;
            poked = 1;
         end
         tick();
         start = 1'b0;
         bus.s_data = bytes[idx <= NBYTES ? idx : NBYTES];
         guard++;
      end
      if (guard >= GUARD) guard_hit = 1;
   endtask

   task automatic verify_complete();
      check("timeout", guard_hit, 0);
      check("shift_count", head_q.size(), CHAIN_LEN);
      check("head_bits", got_bits(CHAIN_LEN), exp_bits(CHAIN_LEN));
`ifdef CFG_CRC_EN
      check("accept_count", acc_cyc.size(), NBYTES + 1);
`else
      check("accept_count", acc_cyc.size(), NBYTES);
      for (int k = 1; k < NBYTES; k++)
         check("accept_spacing", acc_cyc[k] - acc_cyc[k-1], 9);
      check("fabric_release_cycle", cyc, last_shift_cyc + 1);
`endif
      check("done_flag", cfg_done, 1);
      check("done_fabric_reset", fabric_reset, 0);
      check("done_busy", busy, 0);
      check("done_err", cfg_err, 0);
      check("done_shift_en", ccff_shift_en, 0);
   endtask

   initial begin
      int n;
      bit ready_seen;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;

      reset_n = 1'b0;
      repeat (3) tick();
      check("rst_s_ready", bus.s_ready, 0);
      check("rst_head", ccff_head, 0);
      check("rst_shift_en", ccff_shift_en, 0);
      check("rst_fabric_reset", fabric_reset, 1);
      check("rst_busy", busy, 0);
      check("rst_done", cfg_done, 0);
      check("rst_err", cfg_err, 0);
      reset_n = 1'b1;
      tick();

      // Full load with a stray start pulse while busy.
      run_load(0, 1'b1, 1'b0);
      verify_complete();
      n = head_q.size();
      ready_seen = 0;
      repeat (6) begin
         if (bus.s_ready === 1'b1) ready_seen = 1;
         tick();
      end
      check("extra_byte_refused", ready_seen, 0);
      check("no_extra_shift", head_q.size(), n);

      // Restart from DONE.
      run_load(0, 1'b0, 1'b0);
      verify_complete();

      // start and abort together from DONE.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("startabort_busy", busy, 0);
      check("startabort_done", cfg_done, 0);
      check("startabort_fabric", fabric_reset, 1);
      check("startabort_ready", bus.s_ready, 0);

      // Abort after 10 bits.
      run_load(10, 1'b0, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_shift_en", ccff_shift_en, 0);
      check("abort_busy", busy, 0);
      check("abort_fabric", fabric_reset, 1);
      check("abort_ready", bus.s_ready, 0);
      repeat (12) tick();
      check("abort_shift_count", head_q.size(), 10);
      check("abort_head_bits", got_bits(10), exp_bits(10));

      // Reload after abort.
      run_load(0, 1'b0, 1'b0);
      verify_complete();

`ifdef CFG_CRC_EN
      run_load(0, 1'b0, 1'b1);
      check("crc_err_flag", cfg_err, 1);
      check("crc_err_done", cfg_done, 0);
      check("crc_err_fabric", fabric_reset, 1);
      check("crc_err_busy", busy, 0);
`endif

      // Reset in the middle of the first byte.
      run_load(5, 1'b0, 1'b0);
      reset_n = 1'b0;
      tick();
      check("midrst_s_ready", bus.s_ready, 0);
      check("midrst_head", ccff_head, 0);
      check("midrst_shift_en", ccff_shift_en, 0);
      check("midrst_fabric", fabric_reset, 1);
      check("midrst_busy", busy, 0);
      check("midrst_done", cfg_done, 0);
      check("midrst_err", cfg_err, 0);
      reset_n = 1'b1;
      ready_seen = 0;
      repeat (20) begin
         if (bus.s_ready === 1'b1) ready_seen = 1;
         tick();
      end
      check("midrst_no_ready", ready_seen, 0);
      check("midrst_no_shift", head_q.size(), 5);

      bus.s_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
